// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 Hz VGA raster timing from a 50 MHz clock, with a
//            sync/blank delay line and frame-start / VSYNC-toggle indications.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    output logic       pixel_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic       vsync_toggle
);

    localparam logic [9:0] c_h_total    = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] c_v_total    = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] c_h_visible  = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_visible  = 10'(V_VISIBLE);
    localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic       r_pix_ce;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       r_frame_start;
    logic       r_vsync_toggle;

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic       w_blank_raw;

    assign w_h_wrap = (r_h == c_h_total - 10'd1);
    assign w_v_wrap = (r_v == c_v_total - 10'd1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pix_ce       <= 1'b0;
            r_h            <= 10'd0;
            r_v            <= 10'd0;
            r_frame_start  <= 1'b0;
            r_vsync_toggle <= 1'b0;
        end else begin
            r_pix_ce      <= ~r_pix_ce;
            r_frame_start <= 1'b0;
            if (r_pix_ce) begin
                if (w_h_wrap) begin
                    r_h <= 10'd0;
                    if (w_v_wrap) begin
                        r_v            <= 10'd0;
                        r_frame_start  <= 1'b1;
                        r_vsync_toggle <= ~r_vsync_toggle;
                    end else begin
                        r_v <= r_v + 10'd1;
                    end
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    // Gating with RESET_N keeps blank low during reset even with no delay stages.
    assign w_hs_raw    = ~(RESET_N && (r_h >= c_hs_start) && (r_h < c_hs_end));
    assign w_vs_raw    = ~(RESET_N && (r_v >= c_vs_start) && (r_v < c_vs_end));
    assign w_blank_raw = RESET_N && (r_h < c_h_visible) && (r_v < c_v_visible);

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hs    = w_hs_raw;
            assign vs    = w_vs_raw;
            assign blank = w_blank_raw;
        end else begin : g_delay
            // Each stage holds {hs, vs, blank}; stage 0 takes the raw decode.
            logic [PIPE_DELAY-1:0][2:0] r_pipe;

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        r_pipe[i] <= 3'b110;
                    end
                end else if (r_pix_ce) begin
                    r_pipe[0] <= {w_hs_raw, w_vs_raw, w_blank_raw};
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign hs    = r_pipe[PIPE_DELAY-1][2];
            assign vs    = r_pipe[PIPE_DELAY-1][1];
            assign blank = r_pipe[PIPE_DELAY-1][0];
        end
    endgenerate

    assign pixel_ce     = r_pix_ce;
    assign DrawX        = r_h;
    assign DrawY        = r_v;
    assign frame_start  = r_frame_start;
    assign vsync_toggle = r_vsync_toggle;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench; three timing generators compared each CLK
//            against an arithmetic model derived from elapsed clock count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic CLK = 1'b0;
    logic RESET_N;

    always #10 CLK = ~CLK;

    // Default-geometry instance (PIPE_DELAY=1)
    logic       d_ce, d_hs, d_vs, d_bl, d_fs, d_tg;
    logic [9:0] d_x, d_y;
    // Reduced-geometry instances, PIPE_DELAY 0 and 3
    logic       a_ce, a_hs, a_vs, a_bl, a_fs, a_tg;
    logic [9:0] a_x, a_y;
    logic       b_ce, b_hs, b_vs, b_bl, b_fs, b_tg;
    logic [9:0] b_x, b_y;

    vga_timing_gen dut_def (
        .CLK(CLK), .RESET_N(RESET_N), .pixel_ce(d_ce), .DrawX(d_x), .DrawY(d_y),
        .hs(d_hs), .vs(d_vs), .blank(d_bl), .frame_start(d_fs), .vsync_toggle(d_tg)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(0)
    ) dut_s0 (
        .CLK(CLK), .RESET_N(RESET_N), .pixel_ce(a_ce), .DrawX(a_x), .DrawY(a_y),
        .hs(a_hs), .vs(a_vs), .blank(a_bl), .frame_start(a_fs), .vsync_toggle(a_tg)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(3)
    ) dut_s3 (
        .CLK(CLK), .RESET_N(RESET_N), .pixel_ce(b_ce), .DrawX(b_x), .DrawY(b_y),
        .hs(b_hs), .vs(b_vs), .blank(b_bl), .frame_start(b_fs), .vsync_toggle(b_tg)
    );

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;   // CLK edges since reset release
    bit in_rst;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s t=%0d: got %h expected %h", tag, t, obs, exp);
        end
    endtask

    // Expected {pixel_ce, DrawX, DrawY, hs, vs, blank, frame_start, vsync_toggle}
    function automatic logic [31:0] model(input int tc, input bit rst,
                                          input int hv, input int hf, input int hsw, input int hb,
                                          input int vv, input int vf, input int vsw, input int vb,
                                          input int dly);
        int ht, vt, p, q, qh, qv, ft;
        logic [9:0] h, v;
        logic pce, e_hs, e_vs, e_bl, e_fs, e_tg;
        if (rst) return {6'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ht  = hv + hf + hsw + hb;
        vt  = vv + vf + vsw + vb;
        ft  = ht * vt;
        p   = tc / 2;
        pce = (tc % 2) == 1;
        h   = 10'(p % ht);
        v   = 10'((p / ht) % vt);
        if (p >= dly) begin
            q    = p - dly;
            qh   = q % ht;
            qv   = (q / ht) % vt;
            e_hs = !(qh >= hv + hf && qh < hv + hf + hsw);
            e_vs = !(qv >= vv + vf && qv < vv + vf + vsw);
            e_bl = (qh < hv) && (qv < vv);
        end else begin
            e_hs = 1'b1;
            e_vs = 1'b1;
            e_bl = 1'b0;
        end
        e_fs = (tc % 2 == 0) && (p > 0) && (p % ft == 0);
        e_tg = ((p / ft) % 2) == 1;
        return {6'd0, pce, h, v, e_hs, e_vs, e_bl, e_fs, e_tg};
    endfunction

    task automatic check_all();
        check_vec("def_d1", {6'd0, d_ce, d_x, d_y, d_hs, d_vs, d_bl, d_fs, d_tg},
                  model(t, in_rst, 640, 16, 96, 48, 480, 10, 2, 33, 1));
        check_vec("small_d0", {6'd0, a_ce, a_x, a_y, a_hs, a_vs, a_bl, a_fs, a_tg},
                  model(t, in_rst, 16, 2, 4, 3, 12, 2, 2, 3, 0));
        check_vec("small_d3", {6'd0, b_ce, b_x, b_y, b_hs, b_vs, b_bl, b_fs, b_tg},
                  model(t, in_rst, 16, 2, 4, 3, 12, 2, 2, 3, 3));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge CLK);
            if (RESET_N) t++;
            @(negedge CLK);
            check_all();
        end
    endtask

    // Called just after a falling edge: assert reset between edges, hold, release.
    task automatic do_reset(input int n);
        #2;
        RESET_N = 1'b0;
        in_rst  = 1'b1;
        t       = 0;
        #1 check_all();
        repeat (n) begin
            @(negedge CLK);
            check_all();
        end
        #1;
        RESET_N = 1'b1;
        in_rst  = 1'b0;
        #1 check_all();
    endtask

    initial begin
        RESET_N = 1'b0;
        in_rst  = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check_all();
        end
        #1;
        RESET_N = 1'b1;
        in_rst  = 1'b0;
        #1 check_all();
        run(4000);
        for (int k = 0; k < 8; k++) begin
            run($urandom_range(200, 2500));
            do_reset($urandom_range(1, 4));
        end
        run(2000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

VGA 640x480@60 Hz raster timing generator for the text-mode display path. It divides the 50 MHz system clock into a 25 MHz pixel enable and runs the horizontal and vertical counters. From those it produces DrawX/DrawY, the hs/vs syncs and the active-video flag. It feeds the text-mode Avalon interface, which fetches VRAM/font data and registers RGB, and it adds an optional sync/blank delay line so sync stays aligned with that registered pixel pipeline. It also provides frame-start and VSYNC-toggle indications for software synchronisation.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DELAY, 1, pixel periods (0..4) by which hs/vs/blank lag DrawX/DrawY

Ports:
- CLK  in  1  50 MHz system clock; the only clock in the block
- RESET_N  in  1  asynchronous, active-low reset
- pixel_ce  out  1  pixel clock enable, high on every other CLK
- DrawX  out  10  current horizontal counter, 0..H_TOTAL-1
- DrawY  out  10  current vertical counter, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  high = active video; low = blanking (downstream must drive black)
- frame_start  out  1  one-CLK pulse when the counters wrap to (0,0)
- vsync_toggle  out  1  inverts once per frame, on the frame_start cycle

## Operation
- Totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525 by default). All compares are 10-bit unsigned.
- Pixel enable: a 1-bit register resets to 0 and toggles on every CLK. pixel_ce is that register.
- Counters advance only on CLK edges where pixel_ce=1.
  - h counts 0..H_TOTAL-1, then wraps to 0.
  - v increments only when h wraps. When h and v both wrap together, v goes to 0.
- DrawX = h and DrawY = v, driven directly from the counter registers.
- Raw decode, combinational from h/v:
  - hs_raw = 0 iff H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC (656..751 by default).
  - vs_raw = 0 iff V_VISIBLE+V_FP <= v < V_VISIBLE+V_FP+V_SYNC (490..491 by default).
  - blank_raw = 1 iff h < H_VISIBLE and v < V_VISIBLE.
- Delay line:
  - PIPE_DELAY=0: hs/vs/blank equal the raw decode.
  - PIPE_DELAY=N: a shift register of N stages, advanced only when pixel_ce=1.
- frame_start: registered. It is asserted for exactly one CLK: the CLK immediately after the edge on which h and v both wrap to 0.
- vsync_toggle: register reset to 0, inverted on the same edge that asserts frame_start.
- No states other than the counters. There is no start handshake: generation begins at reset release.

## Timing
- Reset values, held while RESET_N=0 and asynchronous on assertion:
  - pixel_ce=0, h=v=0, DrawX=DrawY=0
  - every delay stage: hs=1, vs=1, blank=0
  - frame_start=0, vsync_toggle=0
- While RESET_N=0 the blank output is 0 for every PIPE_DELAY, including 0. The raw decode is forced to the inactive values during reset.
- First CLK edge after release: pixel_ce goes to 1. On the next edge, h goes to 1.
- Each pixel therefore lasts 2 CLK. One line is H_TOTAL*2 = 1600 CLK. One frame is 800*525*2 = 840000 CLK.
- hs/vs/blank lag DrawX/DrawY by PIPE_DELAY pixel periods (PIPE_DELAY*2 CLK).
- Reset asserted mid-frame: everything returns immediately to the reset values. After release, counting restarts from (0,0) with no frame_start pulse for the restart.
- Simultaneous h wrap and v wrap: v goes to 0 (not V_TOTAL), and frame_start fires.

## Test plan
- Reset then release, PIPE_DELAY=0: during reset all outputs equal the reset values. Then pixel_ce reads 1,0,1,0 over the first 4 CLKs, and DrawX reads 0,0,1,1,2.
- Line check: over one line, hs is low for exactly 192 consecutive CLK starting when DrawX=656. blank is high for exactly 1280 CLK (DrawX 0..639) on lines 0..479.
- Frame check: vs is low while DrawY is 490..491, i.e. 3200 CLK. frame_start pulses exactly once per 840000 CLK, and vsync_toggle alternates 0->1->0 over two frames.
- PIPE_DELAY=1: blank falls 2 CLK after DrawX changes 639->640. hs falls 2 CLK after DrawX reaches 656.
- Mid-frame reset at DrawY=300, DrawX=400: within the reset, DrawX=DrawY=0, hs=vs=1, blank=0 and vsync_toggle=0. After release the next frame_start comes 840000 CLK later.
- Wrap boundary: at DrawX=799, DrawY=524 the next pixel is (0,0), and frame_start is high for exactly 1 CLK with DrawX=DrawY=0.
